// File: rtl/risc_v_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, FSM states,
// datapath mux selects and the packed control bundle.
package risc_v_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNC3_W  = 3;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I     = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_B     = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR  = 7'b1100111;

    localparam logic [FUNC3_W-1:0] F3_BEQ = 3'b000;
    localparam logic [FUNC3_W-1:0] F3_BNE = 3'b001;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALUWB     = 4'd8,
        S_BRANCH    = 4'd9,
        S_LUI       = 4'd10,
        S_JAL       = 4'd11,
        S_JALR      = 4'd12,
        S_JALR_JUMP = 4'd13
    } state_e;

    localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU     = 2'b10;
    localparam logic [SEL_W-1:0] RES_IMM     = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALU_ADD  = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB  = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNC = 2'b10;

    typedef struct packed {
        logic             pc_write;
        logic             pc_write_cond;
        logic             bne;
        logic             ir_write;
        logic             adr_src;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic             illegal_instr;
    } ctrl_t;

    // True for every opcode the multicycle sequencer knows how to execute.
    function automatic logic is_supported_op(input logic [OPCODE_W-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_B,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/risc_v_multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
interface risc_v_multicycle_ctrl_if;
    import risc_v_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic [FUNC3_W-1:0]  func3;
    logic                mem_ready;

    logic                pc_write;
    logic                pc_write_cond;
    logic                bne;
    logic                ir_write;
    logic                adr_src;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic [SEL_W-1:0]    result_src;
    logic [SEL_W-1:0]    alu_src_a;
    logic [SEL_W-1:0]    alu_src_b;
    logic [SEL_W-1:0]    alu_op;
    logic                illegal_instr;
    logic [STATE_W-1:0]  state;

    modport master (
        input  opcode, func3, mem_ready,
        output pc_write, pc_write_cond, bne, ir_write, adr_src, mem_read,
               mem_write, reg_write, result_src, alu_src_a, alu_src_b,
               alu_op, illegal_instr, state
    );

    modport slave (
        output opcode, func3, mem_ready,
        input  pc_write, pc_write_cond, bne, ir_write, adr_src, mem_read,
               mem_write, reg_write, result_src, alu_src_a, alu_src_b,
               alu_op, illegal_instr, state
    );

endinterface

// File: rtl/risc_v_multicycle_ctrl_out_decode.sv
// Combinational output decode: Moore outputs per state, plus the func3-driven
// branch qualifiers and the mem_ready-gated fetch enables.
module risc_v_mc_out_decode
    import risc_v_pkg::*;
(
    input  logic [STATE_W-1:0]  state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNC3_W-1:0]  func3_i,
    input  logic                mem_ready_i,
    output ctrl_t               ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.adr_src    = 1'b0;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.result_src = RES_ALU;
                ctrl_o.pc_write   = mem_ready_i;
                ctrl_o.ir_write   = mem_ready_i;
            end
            S_DECODE: begin
                // ALUOut <= OldPC + imm serves branch, JAL and AUIPC targets
                ctrl_o.alu_src_a     = SRCA_OLDPC;
                ctrl_o.alu_src_b     = SRCB_IMM;
                ctrl_o.alu_op        = ALU_ADD;
                ctrl_o.illegal_instr = ~is_supported_op(opcode_i);
            end
            S_MEMADR, S_JALR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl_o.adr_src  = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_MEMDATA;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.adr_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALU_FUNC;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_FUNC;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALU_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                if (func3_i == F3_BEQ || func3_i == F3_BNE) begin
                    ctrl_o.pc_write_cond = 1'b1;
                    ctrl_o.bne           = (func3_i == F3_BNE);
                end else begin
                    ctrl_o.illegal_instr = 1'b1;
                end
            end
            S_LUI: begin
                ctrl_o.result_src = RES_IMM;
                ctrl_o.reg_write  = 1'b1;
            end
            S_JAL, S_JALR_JUMP: begin
                // PC takes the target from ALUOut while the ALU forms the link value
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALU_ADD;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/risc_v_multicycle_ctrl.sv
// Multicycle RISC-V control FSM: state register and next-state sequencing over a
// shared ALU and unified memory port, with the output decode in a sub-module.
module risc_v_multicycle_ctrl
    import risc_v_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    risc_v_multicycle_ctrl_if.master        ctrl_if
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl;
    logic               fetch_ready;

    // Keeps PC/IR loads off while reset is held, whatever memory reports
    assign fetch_ready = ctrl_if.mem_ready & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (ctrl_if.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ctrl_if.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_B:              state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (ctrl_if.opcode == OP_LOAD)       state_d = S_MEMREAD;
                else if (ctrl_if.opcode == OP_STORE) state_d = S_MEMWRITE;
                else                                 state_d = S_FETCH;
            end
            S_MEMREAD: begin
                if (ctrl_if.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (ctrl_if.mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I, S_JAL, S_JALR_JUMP: state_d = S_ALUWB;
            S_JALR:                                 state_d = S_JALR_JUMP;
            S_MEMWB, S_ALUWB, S_BRANCH, S_LUI:      state_d = S_FETCH;
            default:                                state_d = S_FETCH;
        endcase
    end

    risc_v_mc_out_decode u_out_decode (
        .state_i     (state_q),
        .opcode_i    (ctrl_if.opcode),
        .func3_i     (ctrl_if.func3),
        .mem_ready_i (fetch_ready),
        .ctrl_o      (ctrl)
    );

    assign ctrl_if.pc_write      = ctrl.pc_write;
    assign ctrl_if.pc_write_cond = ctrl.pc_write_cond;
    assign ctrl_if.bne           = ctrl.bne;
    assign ctrl_if.ir_write      = ctrl.ir_write;
    assign ctrl_if.adr_src       = ctrl.adr_src;
    assign ctrl_if.mem_read      = ctrl.mem_read;
    assign ctrl_if.mem_write     = ctrl.mem_write;
    assign ctrl_if.reg_write     = ctrl.reg_write;
    assign ctrl_if.result_src    = ctrl.result_src;
    assign ctrl_if.alu_src_a     = ctrl.alu_src_a;
    assign ctrl_if.alu_src_b     = ctrl.alu_src_b;
    assign ctrl_if.alu_op        = ctrl.alu_op;
    assign ctrl_if.illegal_instr = ctrl.illegal_instr;
    assign ctrl_if.state         = state_q;

endmodule

// File: doc/risc_v_multicycle_ctrl.md
# risc_v_multicycle_ctrl

Multicycle control FSM for the RISC-V core, replacing single-cycle decode when the datapath shares one ALU and one unified instruction/data memory port. Sequences fetch, decode, execute, memory and writeback over several cycles. Drives mux selects and register/memory enables into the datapath, and stalls on a memory-ready handshake. Covers the same instruction subset as the single-cycle core: R, I, LOAD, S, BEQ/BNE, LUI, AUIPC, JAL, JALR.

## Interface
- No parameters. Opcode, state and select encodings come from the shared package.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- opcode  in  7  instruction register bits [6:0], valid from DECODE onward.
- func3  in  3  instruction register bits [14:12].
- mem_ready  in  1  unified memory has completed the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by the ALU zero flag.
- bne  out  1  inverts the zero qualification; meaningful only with pc_write_cond.
- ir_write  out  1  load the instruction register and OldPC.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write.
- result_src  out  2  result mux select: 00 ALUOut, 01 MemData, 10 ALU result, 11 immediate.
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 register.
- alu_src_b  out  2  ALU B select: 00 rs2 register, 01 immediate, 10 constant 4.
- alu_op  out  2  ALU operation: 00 add, 01 subtract, 10 decode from func3/func7.
- illegal_instr  out  1  one-cycle pulse in DECODE or BRANCH for an unsupported opcode or func3.
- state  out  4  current state, for debug.

## Operation
- Moore outputs are decoded from the state only. Exceptions:
  - bne is taken from func3.
  - pc_write and ir_write in FETCH are gated by mem_ready.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - Hold while mem_ready=0.
  - When mem_ready=1: pc_write=1 and ir_write=1, then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (computes the branch/JAL/AUIPC target into ALUOut). Next state by opcode:
  - LOAD or S → MEMADR.
  - R → EXEC_R.
  - I → EXEC_I.
  - B → BRANCH.
  - LUI → LUI.
  - AUIPC → ALUWB.
  - JAL → JAL.
  - JALR → JALR.
  - Any other opcode → FETCH with illegal_instr=1.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD for LOAD, MEMWRITE for S.
- MEMREAD: adr_src=1, mem_read=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held until mem_ready, then FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, then FETCH.
  - func3=000: pc_write_cond=1, bne=0.
  - func3=001: pc_write_cond=1, bne=1.
  - Any other func3: pc_write_cond=0 and illegal_instr=1.
- LUI: result_src=11, reg_write=1, then FETCH.
- JAL: pc_write=1, result_src=00 (target taken from ALUOut); ALU computes OldPC+4 (a=01, b=10, op=00). Then ALUWB.
- JALR: alu_src_a=10, alu_src_b=01, alu_op=00 (rs1+imm), then JALR_JUMP.
- JALR_JUMP: pc_write=1, result_src=00; ALU computes OldPC+4. Then ALUWB.

## Timing
- Reset:
  - State is forced to FETCH asynchronously, with rst_n asserted or mid-instruction.
  - Outputs take the FETCH decode: mem_read=1, alu_src_b=10, result_src=10, all enables 0.
  - pc_write and ir_write stay 0 while rst_n=0, regardless of mem_ready.
- Cycles per instruction with zero-wait memory:
  - branch, LUI, AUIPC: 3.
  - R, I, store, JAL: 4.
  - load, JALR: 5.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Handshake:
  - Memory outputs stay stable while waiting.
  - mem_ready is ignored in all other states.
  - mem_ready is sampled at the rising edge on which the state advances.
- At most one of reg_write and mem_write is high in any cycle. pc_write and pc_write_cond are never high together.

## Structure
- Shared package risc_v_pkg holds:
  - opcode constants;
  - the state enum (4-bit, FETCH=0);
  - result_src, alu_src_a, alu_src_b and alu_op encodings;
  - func3 constants for BEQ and BNE.
- Sub-module risc_v_mc_out_decode: purely combinational, state/func3/mem_ready → control outputs.
- The top keeps the state register and next-state logic.

## Test plan
- R-type add (0x00B50533), mem_ready tied high → states FETCH, DECODE, EXEC_R, ALUWB; reg_write high only in cycle 4; back in FETCH in cycle 5.
- Load (0x00052283) with mem_ready low for 2 cycles in MEMREAD → MEMREAD held 3 cycles with adr_src=1; MEMWB has result_src=01 and reg_write=1; 7 cycles total.
- BNE (func3=001) → BRANCH with pc_write_cond=1, bne=1, alu_op=01. func3=100 → illegal_instr pulse and no PC write.
- JALR → pc_write only in JALR_JUMP, rd written in ALUWB; 5 cycles.
- Opcode 0x7F → illegal_instr for 1 cycle in DECODE, then FETCH; no write enable asserted.
- rst_n dropped mid-MEMWRITE → state is FETCH immediately without waiting for clk, mem_write=0; normal fetch resumes after release.
